mipi_csi_rx_crc_checker: RTL and testbench

Downstream consumer of the CSI-2 RX packet decoder. It accumulates the CSI-2 payload CRC-16 over up to 4 payload bytes per cycle. It compares the result with the received packet checksum and counts payload bytes against the header word count. It reports a per-packet CRC/length status to the RX controller and the register file.

---
 rtl/mipi_csi_rx_pkg.sv | 19 +
 rtl/mipi_csi_rx_crc16_byte.sv | 37 +++
 rtl/mipi_csi_rx_crc_checker.sv | 188 ++++++++++++++++++
 tb/tb_mipi_csi_rx_crc_checker.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_csi_rx_pkg.sv
// mipi_csi_rx_pkg
// Shared constants and types for the CSI-2 RX payload CRC checker.
//   CRC_POLY_REFL    : CSI-2 CRC-16 polynomial x^16+x^12+x^5+1, bit-reflected
//   CRC_SEED_DEFAULT : CRC register value loaded at every packet start
//   NUM_LANES_MAX    : number of byte lanes delivered per cycle
//   crc_state_t      : checker FSM states
package mipi_csi_rx_pkg;

  localparam logic [15:0] CRC_POLY_REFL    = 16'h8408;
  localparam logic [15:0] CRC_SEED_DEFAULT = 16'hFFFF;
  localparam int          NUM_LANES_MAX    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CHECK = 2'd2
  } crc_state_t;

endpackage

// File: rtl/mipi_csi_rx_crc16_byte.sv
// mipi_csi_rx_crc16_byte
// Combinational single-byte update of the CSI-2 CRC-16. The byte is consumed
// LSB first against the reflected polynomial; when en_i is low the CRC passes
// through unchanged so a skipped lane costs nothing in the cascade.
// Ports:
//   crc_i  [15:0] : CRC before this byte
//   byte_i [7:0]  : payload byte
//   en_i          : byte is valid and must be folded in
//   crc_o  [15:0] : CRC after this byte
module mipi_csi_rx_crc16_byte
  import mipi_csi_rx_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  byte_i,
  input  logic        en_i,
  output logic [15:0] crc_o
);

  logic [15:0] crcWork;

  // Eight serial shift steps unrolled into one combinational cone; the
  // feedback bit is the CRC LSB xor the current data bit.
  always_comb begin
    crcWork = crc_i;
    if (en_i) begin
      for (int b = 0; b < 8; b++) begin
        if (crcWork[0] ^ byte_i[b]) begin
          crcWork = (crcWork >> 1) ^ CRC_POLY_REFL;
        end else begin
          crcWork = crcWork >> 1;
        end
      end
    end
    crc_o = crcWork;
  end

endmodule

// File: rtl/mipi_csi_rx_crc_checker.sv
// mipi_csi_rx_crc_checker
// Accumulates the CSI-2 payload CRC-16 over up to four bytes per cycle,
// compares it with the received packet checksum and checks the payload byte
// count against the header word count. One strobe per completed packet.
// Ports:
//   clk_i, reset_i          : clock, synchronous active-high reset
//   packet_start_i          : long-packet header accepted, reseeds the CRC
//   payload_length_i [15:0] : header word count in bytes (sampled at start)
//   payload_data_i  [4][8]  : payload bytes, lane 3 carries the first byte
//   payload_valid_i [4]     : per-lane byte valid
//   received_crc_i  [15:0]  : received checksum
//   crc_received_valid_i    : checksum valid, marks end of payload
//   computed_crc_o  [15:0]  : final CRC of the last checked packet
//   crc_valid_o             : one-cycle result strobe
//   crc_error_o             : CRC mismatch of the last packet (held)
//   length_error_o          : byte count mismatch of the last packet (held)
//   busy_o                  : packet accumulation in progress
// Optional (MIPI_CSI_RX_CRC_ERR_CNT_EN defined):
//   err_count_clear_i       : zero the error counter
//   crc_err_count_o [15:0]  : saturating count of failed packets
module mipi_csi_rx_crc_checker
  import mipi_csi_rx_pkg::*;
#(
  parameter int          NUM_LANES = NUM_LANES_MAX,
  parameter logic [15:0] CRC_SEED  = CRC_SEED_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        packet_start_i,
  input  logic [15:0] payload_length_i,
  input  logic [7:0]  payload_data_i [NUM_LANES],
  input  logic        payload_valid_i [NUM_LANES],
  input  logic [15:0] received_crc_i,
  input  logic        crc_received_valid_i,
  output logic [15:0] computed_crc_o,
  output logic        crc_valid_o,
  output logic        crc_error_o,
  output logic        length_error_o,
  output logic        busy_o
`ifdef MIPI_CSI_RX_CRC_ERR_CNT_EN
  ,
  input  logic        err_count_clear_i,
  output logic [15:0] crc_err_count_o
`endif
);

  localparam int LCW = $clog2(NUM_LANES + 1);

  crc_state_t  state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [16:0] count_q, count_d;
  logic [15:0] length_q, length_d;
  logic [15:0] computedCrc_q, computedCrc_d;
  logic        crcValid_q, crcValid_d;
  logic        crcError_q, crcError_d;
  logic        lengthError_q, lengthError_d;

  logic [15:0]    crcChain [NUM_LANES+1];
  logic [LCW-1:0] laneCount;
  logic [17:0]    countSum;
  logic [16:0]    countNext;

  // Byte cascade: stage k handles lane NUM_LANES-1-k so the highest lane is
  // folded in first; disabled stages pass the CRC straight through, which
  // also covers non-contiguous masks without special handling.
  assign crcChain[0] = crc_q;
  for (genvar k = 0; k < NUM_LANES; k++) begin : gCrcStage
    mipi_csi_rx_crc16_byte uByte (
      .crc_i  (crcChain[k]),
      .byte_i (payload_data_i[NUM_LANES-1-k]),
      .en_i   (payload_valid_i[NUM_LANES-1-k]),
      .crc_o  (crcChain[k+1])
    );
  end

  // Byte counter update: popcount of the valid mask added to a 17-bit count
  // that sticks at all-ones rather than wrapping back into a legal length.
  always_comb begin
    laneCount = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      laneCount = laneCount + LCW'(payload_valid_i[l]);
    end
    countSum  = {1'b0, count_q} + 18'(laneCount);
    countNext = countSum[17] ? '1 : countSum[16:0];
  end

  // Next-state logic. A start pulse always wins: it reseeds from any state,
  // so a start seen in ACCUM silently abandons the current packet. The packet
  // verdict is computed when the checksum arrives (including any bytes of
  // that same beat) and registered, so it is visible during CHECK.
  always_comb begin
    state_d       = state_q;
    crc_d         = crc_q;
    count_d       = count_q;
    length_d      = length_q;
    computedCrc_d = computedCrc_q;
    crcValid_d    = 1'b0;
    crcError_d    = crcError_q;
    lengthError_d = lengthError_q;
    if (packet_start_i) begin
      state_d  = ACCUM;
      crc_d    = CRC_SEED;
      count_d  = '0;
      length_d = payload_length_i;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        ACCUM: begin
          crc_d   = crcChain[NUM_LANES];
          count_d = countNext;
          if (crc_received_valid_i) begin
            state_d       = CHECK;
            computedCrc_d = crcChain[NUM_LANES];
            crcValid_d    = 1'b1;
            crcError_d    = (crcChain[NUM_LANES] != received_crc_i);
            lengthError_d = (countNext != {1'b0, length_q});
          end
        end
        CHECK: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and status registers; reset drops any packet in flight and clears
  // the reported status without producing a strobe.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      crc_q         <= CRC_SEED;
      count_q       <= '0;
      length_q      <= '0;
      computedCrc_q <= '0;
      crcValid_q    <= 1'b0;
      crcError_q    <= 1'b0;
      lengthError_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      crc_q         <= crc_d;
      count_q       <= count_d;
      length_q      <= length_d;
      computedCrc_q <= computedCrc_d;
      crcValid_q    <= crcValid_d;
      crcError_q    <= crcError_d;
      lengthError_q <= lengthError_d;
    end
  end

  assign computed_crc_o = computedCrc_q;
  assign crc_valid_o    = crcValid_q;
  assign crc_error_o    = crcError_q;
  assign length_error_o = lengthError_q;
  assign busy_o         = (state_q == ACCUM);

`ifdef MIPI_CSI_RX_CRC_ERR_CNT_EN
  logic [15:0] errCount_q, errCount_d;

  // Failed-packet counter: counts CHECK cycles that report any error, holds
  // at all-ones, and a clear request overrides a same-cycle increment.
  always_comb begin
    errCount_d = errCount_q;
    if (err_count_clear_i) begin
      errCount_d = '0;
    end else if (crcValid_q && (crcError_q || lengthError_q) &&
                 (errCount_q != 16'hFFFF)) begin
      errCount_d = errCount_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      errCount_q <= '0;
    end else begin
      errCount_q <= errCount_d;
    end
  end

  assign crc_err_count_o = errCount_q;
`endif

endmodule

// File: tb/tb_mipi_csi_rx_crc_checker.sv
// tb_mipi_csi_rx_crc_checker
// Directed, table-driven bench for mipi_csi_rx_crc_checker. Expected CRCs come
// from the published CSI-2 example (16'h00F0) and from an MSB-first reference
// CRC model in the bench. Counter checks only exist with
// MIPI_CSI_RX_CRC_ERR_CNT_EN defined.
module tb_mipi_csi_rx_crc_checker;

  logic        clk_i;
  logic        reset_i;
  logic        packet_start_i;
  logic [15:0] payload_length_i;
  logic [7:0]  payload_data_i [4];
  logic        payload_valid_i [4];
  logic [15:0] received_crc_i;
  logic        crc_received_valid_i;
  logic [15:0] computed_crc_o;
  logic        crc_valid_o;
  logic        crc_error_o;
  logic        length_error_o;
  logic        busy_o;
`ifdef MIPI_CSI_RX_CRC_ERR_CNT_EN
  logic        err_count_clear_i;
  logic [15:0] crc_err_count_o;
`endif

  mipi_csi_rx_crc_checker dut (
    .clk_i                (clk_i),
    .reset_i              (reset_i),
    .packet_start_i       (packet_start_i),
    .payload_length_i     (payload_length_i),
    .payload_data_i       (payload_data_i),
    .payload_valid_i      (payload_valid_i),
    .received_crc_i       (received_crc_i),
    .crc_received_valid_i (crc_received_valid_i),
    .computed_crc_o       (computed_crc_o),
    .crc_valid_o          (crc_valid_o),
    .crc_error_o          (crc_error_o),
    .length_error_o       (length_error_o),
    .busy_o               (busy_o)
`ifdef MIPI_CSI_RX_CRC_ERR_CNT_EN
    ,
    .err_count_clear_i    (err_count_clear_i),
    .crc_err_count_o      (crc_err_count_o)
`endif
  );

  typedef struct {
    int          byteSet;
    int          lanes;
    int          len;
    logic [15:0] rxCrc;
    logic [15:0] expCrc;
    logic        expCrcErr;
    logic        expLenErr;
  } vec_t;

  localparam int NV = 9;

  vec_t        vecs [NV];
  logic [7:0]  pktBytes [$];
  logic [7:0]  exBytes [24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC,
                                8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
                                8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8,
                                8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
  int          errors = 0;
  int          checks = 0;
  int          strobeCount = 0;
  int          expStrobes = 0;
  logic [15:0] m5;

  // Free-running clock.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Count result strobes mid-cycle, far from the sampling edge.
  always @(negedge clk_i) begin
    if (crc_valid_o === 1'b1) strobeCount++;
  end

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int c = 0; c < n; c++) stepCycle();
  endtask

  task automatic clearLanes();
    for (int l = 0; l < 4; l++) begin
      payload_valid_i[l] = 1'b0;
      payload_data_i[l]  = 8'h00;
    end
  endtask

  task automatic loadSet(input int s);
    pktBytes.delete();
    if (s == 0) begin
      for (int n = 0; n < 24; n++) pktBytes.push_back(exBytes[n]);
    end else if (s == 1) begin
      for (int n = 1; n <= 5; n++) pktBytes.push_back(8'(n));
    end
  endtask

  // Reference CRC in the non-reflected MSB-first form on a bit-reversed
  // register (poly 16'h1021), reflected back at the end.
  function automatic logic [15:0] crcModel();
    logic [15:0] r;
    logic [15:0] out;
    logic        fb;
    r = 16'hFFFF;
    foreach (pktBytes[n]) begin
      for (int b = 0; b < 8; b++) begin
        fb = r[15] ^ pktBytes[n][b];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h1021;
      end
    end
    for (int b = 0; b < 16; b++) out[b] = r[15-b];
    return out;
  endfunction

  // Sends pktBytes on the given lane count (lane 3 first). The checksum rides
  // on the last payload beat when crcOnLast is set, otherwise it gets its
  // own beat. Returns positioned in the CHECK cycle.
  task automatic applyStimulus(input int lanes, input int len,
                               input logic [15:0] rxCrc, input bit crcOnLast,
                               input bit startedAlready);
    int idx;
    int nb;
    if (!startedAlready) begin
      packet_start_i   = 1'b1;
      payload_length_i = len[15:0];
      stepCycle();
      packet_start_i   = 1'b0;
    end
    nb  = pktBytes.size();
    idx = 0;
    while (idx < nb) begin
      clearLanes();
      for (int k = 0; k < lanes && idx < nb; k++) begin
        payload_valid_i[3-k] = 1'b1;
        payload_data_i[3-k]  = pktBytes[idx];
        idx++;
      end
      if (idx == nb && crcOnLast) begin
        crc_received_valid_i = 1'b1;
        received_crc_i       = rxCrc;
      end
      stepCycle();
    end
    clearLanes();
    if (!(crcOnLast && nb > 0)) begin
      crc_received_valid_i = 1'b1;
      received_crc_i       = rxCrc;
      stepCycle();
    end
    crc_received_valid_i = 1'b0;
    received_crc_i       = 16'hDEAD;
  endtask

  initial begin
    reset_i              = 1'b1;
    packet_start_i       = 1'b0;
    payload_length_i     = 16'h0;
    received_crc_i       = 16'h0;
    crc_received_valid_i = 1'b0;
    clearLanes();
`ifdef MIPI_CSI_RX_CRC_ERR_CNT_EN
    err_count_clear_i    = 1'b0;
`endif

    loadSet(1);
    m5 = crcModel();

    vecs[0] = '{0, 4, 24, 16'h00F0, 16'h00F0, 1'b0, 1'b0};
    vecs[1] = '{0, 1, 24, 16'h00F0, 16'h00F0, 1'b0, 1'b0};
    vecs[2] = '{0, 2, 24, 16'h00F0, 16'h00F0, 1'b0, 1'b0};
    vecs[3] = '{1, 4, 5,  m5 + 16'd1, m5, 1'b1, 1'b0};
    vecs[4] = '{1, 1, 5,  m5, m5, 1'b0, 1'b0};
    vecs[5] = '{1, 4, 6,  m5, m5, 1'b0, 1'b1};
    vecs[6] = '{2, 4, 0,  16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    vecs[7] = '{0, 3, 24, 16'h00F0, 16'h00F0, 1'b0, 1'b0};
    vecs[8] = '{0, 4, 25, 16'h00F1, 16'h00F0, 1'b1, 1'b1};

    idleCycles(3);
    checkOutput("reset computed_crc", computed_crc_o, 16'h0);
    checkOutput("reset crc_valid", {15'b0, crc_valid_o}, 16'd0);
    checkOutput("reset crc_error", {15'b0, crc_error_o}, 16'd0);
    checkOutput("reset length_error", {15'b0, length_error_o}, 16'd0);
    checkOutput("reset busy", {15'b0, busy_o}, 16'd0);
`ifdef MIPI_CSI_RX_CRC_ERR_CNT_EN
    checkOutput("reset err_count", crc_err_count_o, 16'd0);
`endif
    reset_i = 1'b0;
    idleCycles(2);

    for (int i = 0; i < NV; i++) begin
      loadSet(vecs[i].byteSet);
      applyStimulus(vecs[i].lanes, vecs[i].len, vecs[i].rxCrc, (i % 2) == 0, 1'b0);
      expStrobes++;
      checkOutput($sformatf("v%0d crc_valid", i), {15'b0, crc_valid_o}, 16'd1);
      checkOutput($sformatf("v%0d computed_crc", i), computed_crc_o, vecs[i].expCrc);
      checkOutput($sformatf("v%0d crc_error", i), {15'b0, crc_error_o}, {15'b0, vecs[i].expCrcErr});
      checkOutput($sformatf("v%0d length_error", i), {15'b0, length_error_o}, {15'b0, vecs[i].expLenErr});
      checkOutput($sformatf("v%0d busy in check", i), {15'b0, busy_o}, 16'd0);
      idleCycles(2);
      checkOutput($sformatf("v%0d strobe dropped", i), {15'b0, crc_valid_o}, 16'd0);
      checkOutput($sformatf("v%0d crc held", i), computed_crc_o, vecs[i].expCrc);
      checkOutput($sformatf("v%0d crc_error held", i), {15'b0, crc_error_o}, {15'b0, vecs[i].expCrcErr});
      checkOutput($sformatf("v%0d length_error held", i), {15'b0, length_error_o}, {15'b0, vecs[i].expLenErr});
    end

    // Abort: restart mid-packet, with the restart coinciding with a checksum.
    packet_start_i   = 1'b1;
    payload_length_i = 16'd5;
    stepCycle();
    packet_start_i   = 1'b0;
    checkOutput("abort busy", {15'b0, busy_o}, 16'd1);
    for (int l = 0; l < 4; l++) begin
      payload_valid_i[l] = 1'b1;
      payload_data_i[l]  = 8'hA5;
    end
    stepCycle();
    clearLanes();
    packet_start_i       = 1'b1;
    payload_length_i     = 16'd24;
    crc_received_valid_i = 1'b1;
    received_crc_i       = 16'h1234;
    stepCycle();
    packet_start_i       = 1'b0;
    crc_received_valid_i = 1'b0;
    checkOutput("abort no strobe", {15'b0, crc_valid_o}, 16'd0);
    checkOutput("abort still busy", {15'b0, busy_o}, 16'd1);
    loadSet(0);
    applyStimulus(4, 24, 16'h00F0, 1'b1, 1'b1);
    expStrobes++;
    checkOutput("abort crc_valid", {15'b0, crc_valid_o}, 16'd1);
    checkOutput("abort computed_crc", computed_crc_o, 16'h00F0);
    checkOutput("abort crc_error", {15'b0, crc_error_o}, 16'd0);
    checkOutput("abort length_error", {15'b0, length_error_o}, 16'd0);

    // Back-to-back: new start during the CHECK cycle.
    packet_start_i   = 1'b1;
    payload_length_i = 16'd5;
    stepCycle();
    packet_start_i   = 1'b0;
    checkOutput("b2b busy", {15'b0, busy_o}, 16'd1);
    loadSet(1);
    applyStimulus(4, 5, m5, 1'b0, 1'b1);
    expStrobes++;
    checkOutput("b2b crc_valid", {15'b0, crc_valid_o}, 16'd1);
    checkOutput("b2b computed_crc", computed_crc_o, m5);
    checkOutput("b2b length_error", {15'b0, length_error_o}, 16'd0);
    idleCycles(2);
    checkOutput("strobe total pre-reset", 16'(strobeCount), 16'(expStrobes));

    // Bad packet to set status, then reset in the middle of another one.
    applyStimulus(4, 6, m5 + 16'd1, 1'b0, 1'b0);
    expStrobes++;
    idleCycles(1);
    packet_start_i   = 1'b1;
    payload_length_i = 16'd24;
    stepCycle();
    packet_start_i   = 1'b0;
    for (int l = 0; l < 4; l++) begin
      payload_valid_i[l] = 1'b1;
      payload_data_i[l]  = 8'h3C;
    end
    stepCycle();
    reset_i              = 1'b1;
    crc_received_valid_i = 1'b1;
    received_crc_i       = 16'h0000;
    stepCycle();
    reset_i              = 1'b0;
    crc_received_valid_i = 1'b0;
    clearLanes();
    checkOutput("midreset computed_crc", computed_crc_o, 16'h0);
    checkOutput("midreset crc_valid", {15'b0, crc_valid_o}, 16'd0);
    checkOutput("midreset crc_error", {15'b0, crc_error_o}, 16'd0);
    checkOutput("midreset length_error", {15'b0, length_error_o}, 16'd0);
    checkOutput("midreset busy", {15'b0, busy_o}, 16'd0);
    idleCycles(3);
    checkOutput("strobe total post-reset", 16'(strobeCount), 16'(expStrobes));

`ifdef MIPI_CSI_RX_CRC_ERR_CNT_EN
    checkOutput("err_count after reset", crc_err_count_o, 16'd0);
    for (int p = 0; p < 3; p++) begin
      applyStimulus(4, 5, m5 + 16'd1, 1'b0, 1'b0);
      expStrobes++;
      idleCycles(1);
    end
    checkOutput("err_count three bad", crc_err_count_o, 16'd3);
    applyStimulus(4, 5, m5 + 16'd1, 1'b0, 1'b0);
    expStrobes++;
    err_count_clear_i = 1'b1;
    stepCycle();
    err_count_clear_i = 1'b0;
    checkOutput("err_count clear wins", crc_err_count_o, 16'd0);
    idleCycles(1);
    checkOutput("err_count stays clear", crc_err_count_o, 16'd0);
`endif

    checkOutput("strobe total", 16'(strobeCount), 16'(expStrobes));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
